// File: rtl/towers_hitdetector.sv
// towers_hitdetector
//   Watches per-pixel drawing requests of the player, towers and screen
//   border during each VGA frame. It latches the first player/obstacle
//   overlap of the frame and turns it into one collision event at the frame
//   boundary. It also owns the lives counter, the post-hit invulnerability
//   window and the sticky game-over flag.
//
// Ports
//   clk, resetN             clock, async active-low reset
//   startOfFrame            1-cycle pulse on the first cycle of a frame
//   restart                 1-cycle pulse, reload lives and return to ALIVE
//   pixelX, pixelY          current VGA pixel
//   player/towers/borderDrawingRequest   per-pixel occupancy
//   collisionPulse          1-cycle hit event, the cycle after startOfFrame
//   collisionX/Y, hitKind   first overlap of the hit frame (0 tower, 1 border)
//   lives                   remaining lives
//   invulnerable, gameOver  state flags
module towers_hitdetector #(
  parameter int INITIAL_LIVES = 3,
  parameter int GRACE_FRAMES  = 60
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        restart,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        playerDrawingRequest,
  input  logic        towersDrawingRequest,
  input  logic        borderDrawingRequest,
  output logic        collisionPulse,
  output logic [10:0] collisionX,
  output logic [10:0] collisionY,
  output logic        hitKind,
  output logic [3:0]  lives,
  output logic        invulnerable,
  output logic        gameOver
);

  typedef enum logic [1:0] {ALIVE, GRACE, GAME_OVER} state_t;

  localparam logic [3:0] LIVES_INIT = 4'(INITIAL_LIVES);
  localparam logic [7:0] GRACE_INIT = 8'(GRACE_FRAMES);

  state_t      state, next_state;
  logic        frame_hit;
  logic [10:0] pend_x, pend_y;
  logic        pend_kind;
  logic [7:0]  grace_cnt;

  logic        tower_hit, border_hit, any_hit;
  logic        hit_now, take_hit;
  logic [10:0] eval_x, eval_y;
  logic        eval_kind;

  assign tower_hit  = playerDrawingRequest & towersDrawingRequest;
  assign border_hit = playerDrawingRequest & borderDrawingRequest;
  assign any_hit    = tower_hit | border_hit;

  // An overlap on the startOfFrame cycle belongs to the frame that is ending,
  // so it is folded in here when nothing was latched earlier in the frame.
  assign hit_now   = frame_hit | any_hit;
  assign eval_x    = frame_hit ? pend_x    : pixelX;
  assign eval_y    = frame_hit ? pend_y    : pixelY;
  assign eval_kind = frame_hit ? pend_kind : ~tower_hit;  // tower wins ties

  // A hit only counts in ALIVE; lives != 0 keeps the counter from wrapping.
  assign take_hit = startOfFrame & ~restart & (state == ALIVE) & hit_now &
                    (lives != 4'd0);

  // ---------------- state machine ----------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= ALIVE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (restart) begin
      next_state = ALIVE;
    end else if (startOfFrame) begin
      case (state)
        ALIVE:     if (take_hit) next_state = (lives == 4'd1) ? GAME_OVER : GRACE;
        GRACE:     if (grace_cnt <= 8'd1) next_state = ALIVE;
        GAME_OVER: next_state = GAME_OVER;
        default:   next_state = ALIVE;
      endcase
    end
  end

  assign invulnerable = (state == GRACE);
  assign gameOver     = (state == GAME_OVER);

  // ---------------- frame accumulator ----------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frame_hit <= 1'b0;
      pend_x    <= '0;
      pend_y    <= '0;
      pend_kind <= 1'b0;
    end else if (restart || startOfFrame) begin
      frame_hit <= 1'b0;
    end else if (any_hit && !frame_hit) begin
      frame_hit <= 1'b1;
      pend_x    <= pixelX;
      pend_y    <= pixelY;
      pend_kind <= ~tower_hit;
    end
  end

  // ---------------- grace counter ----------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      grace_cnt <= 8'd0;
    end else if (restart) begin
      grace_cnt <= 8'd0;
    end else if (take_hit && lives != 4'd1) begin
      grace_cnt <= GRACE_INIT;
    end else if (startOfFrame && state == GRACE && grace_cnt != 8'd0) begin
      grace_cnt <= grace_cnt - 8'd1;
    end
  end

  // ---------------- event outputs and lives ----------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      collisionPulse <= 1'b0;
      collisionX     <= '0;
      collisionY     <= '0;
      hitKind        <= 1'b0;
      lives          <= LIVES_INIT;
    end else begin
      collisionPulse <= take_hit;
      if (restart) begin
        lives <= LIVES_INIT;
      end else if (take_hit) begin
        collisionX <= eval_x;
        collisionY <= eval_y;
        hitKind    <= eval_kind;
        lives      <= lives - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_towers_hitdetector.sv
module tb_towers_hitdetector;
  localparam int INIT = 3;
  localparam int GF   = 3;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0, restart = 1'b0;
  logic [10:0] pixelX = '0, pixelY = '0;
  logic        playerDrawingRequest = 1'b0, towersDrawingRequest = 1'b0;
  logic        borderDrawingRequest = 1'b0;
  logic        collisionPulse;
  logic [10:0] collisionX, collisionY;
  logic        hitKind;
  logic [3:0]  lives;
  logic        invulnerable, gameOver;

  towers_hitdetector #(.INITIAL_LIVES(INIT), .GRACE_FRAMES(GF)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .restart(restart),
    .pixelX(pixelX), .pixelY(pixelY),
    .playerDrawingRequest(playerDrawingRequest),
    .towersDrawingRequest(towersDrawingRequest),
    .borderDrawingRequest(borderDrawingRequest),
    .collisionPulse(collisionPulse), .collisionX(collisionX), .collisionY(collisionY),
    .hitKind(hitKind), .lives(lives), .invulnerable(invulnerable), .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  // ---- reference model: frame-level game rules ----
  typedef struct { logic [10:0] x; logic [10:0] y; logic k; } ov_t;
  ov_t         ovq[$];        // every overlap seen in the current frame
  logic        e_pulse = 1'b0;
  logic [10:0] e_x = '0, e_y = '0;
  logic        e_kind = 1'b0;
  int          e_lives = INIT;
  int          e_grace = 0;   // frame boundaries of invulnerability remaining
  logic        e_over = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [29:0] obs, expv;
  assign obs  = {collisionPulse, collisionX, collisionY, hitKind, lives, invulnerable, gameOver};
  assign expv = {e_pulse, e_x, e_y, e_kind, 4'(e_lives), (e_grace > 0), e_over};

  task automatic model_reset();
    ovq.delete();
    e_pulse = 0; e_x = '0; e_y = '0; e_kind = 0;
    e_lives = INIT; e_grace = 0; e_over = 0;
  endtask

  // Drive one clock cycle and advance the model to the post-edge expectation.
  task automatic cyc(input bit sof, input bit rs, input logic [10:0] x, input logic [10:0] y,
                     input bit p, input bit t, input bit b);
    bit th, bh;
    ov_t o;
    th = p & t; bh = p & b;
    startOfFrame = sof; restart = rs; pixelX = x; pixelY = y;
    playerDrawingRequest = p; towersDrawingRequest = t; borderDrawingRequest = b;
    e_pulse = 0;
    if (rs) begin
      ovq.delete();
      e_lives = INIT; e_grace = 0; e_over = 0;
    end else begin
      if (th || bh) begin
        o.x = x; o.y = y; o.k = !th;
        ovq.push_back(o);
      end
      if (sof) begin
        if (!e_over && e_grace == 0 && ovq.size() > 0) begin
          e_pulse = 1; e_x = ovq[0].x; e_y = ovq[0].y; e_kind = ovq[0].k;
          e_lives = e_lives - 1;
          if (e_lives == 0) e_over = 1;
          else              e_grace = GF;
        end else if (e_grace > 0) begin
          e_grace = e_grace - 1;
        end
        ovq.delete();
      end
    end
    @(posedge clk); #1;
  endtask

  // n mid-frame cycles; optional single overlap in the middle
  task automatic frame_body(input int n, input bit hit, input logic [10:0] x, input logic [10:0] y,
                            input bit t, input bit b);
    for (int i = 0; i < n; i++) begin
      if (hit && i == n/2) cyc(0, 0, x, y, 1, t, b);
      else                 cyc(0, 0, 11'(i), 11'(i), (i % 2), 0, 0);
    end
  endtask

  task automatic sof_quiet();
    cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    resetN = 0; model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (obs !== expv) begin n_fail++; $display("FAIL reset_state: got %h want %h", obs, expv); end
    n_tests++;
    if (lives !== 4'd3 || collisionPulse !== 1'b0) begin
      n_fail++; $display("FAIL reset_lives: got lives=%0d pulse=%0b want 3/0", lives, collisionPulse);
    end
    resetN = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_hit();
    sof_quiet();
    cyc(0, 0, 5, 5, 1, 0, 0);
    cyc(0, 0, 120, 200, 1, 1, 0);
    cyc(0, 0, 121, 200, 1, 1, 0);
    cyc(0, 0, 3, 3, 0, 0, 0);
    cyc(0, 0, 130, 215, 1, 1, 0);
    sof_quiet();
    n_tests++;
    if (obs !== expv) begin n_fail++; $display("FAIL single_hit: got %h want %h", obs, expv); end
    n_tests++;
    if ({collisionPulse, collisionX, collisionY, hitKind, lives, invulnerable} !==
        {1'b1, 11'd120, 11'd200, 1'b0, 4'd2, 1'b1}) begin
      n_fail++; $display("FAIL single_hit_values: got p=%0b x=%0d y=%0d k=%0b l=%0d inv=%0b want 1/120/200/0/2/1",
                         collisionPulse, collisionX, collisionY, hitKind, lives, invulnerable);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (collisionPulse !== 1'b0) begin n_fail++; $display("FAIL single_hit_width: got pulse %0b want 0", collisionPulse); end
  endtask

  task automatic test_grace();
    for (int f = 1; f <= GF; f++) begin
      frame_body(6, 1, 11'(200 + f), 100, 1, 0);
      sof_quiet();
      n_tests++;
      if (obs !== expv) begin n_fail++; $display("FAIL grace_frame%0d: got %h want %h", f, obs, expv); end
      n_tests++;
      if (collisionPulse !== 1'b0 || invulnerable !== (f < GF)) begin
        n_fail++; $display("FAIL grace_flag%0d: got p=%0b inv=%0b want 0/%0b", f, collisionPulse, invulnerable, (f < GF));
      end
    end
    frame_body(6, 1, 300, 310, 1, 0);
    sof_quiet();
    n_tests++;
    if ({collisionPulse, collisionX, lives} !== {1'b1, 11'd300, 4'd1}) begin
      n_fail++; $display("FAIL grace_after: got p=%0b x=%0d l=%0d want 1/300/1", collisionPulse, collisionX, lives);
    end
    cyc(0, 1, 0, 0, 0, 0, 0);
    n_tests++;
    if (obs !== expv || lives !== 4'd3 || collisionX !== 11'd300) begin
      n_fail++; $display("FAIL grace_restart: got %h want %h", obs, expv);
    end
  endtask

  task automatic test_simultaneous();
    frame_body(5, 1, 50, 60, 1, 1);
    sof_quiet();
    n_tests++;
    if ({collisionPulse, collisionX, collisionY, hitKind} !== {1'b1, 11'd50, 11'd60, 1'b0} || obs !== expv) begin
      n_fail++; $display("FAIL simul_tower_wins: got %h want %h", obs, expv);
    end
    for (int f = 0; f < GF; f++) begin frame_body(4, 0, 0, 0, 0, 0); sof_quiet(); end
    frame_body(5, 1, 70, 80, 0, 1);
    sof_quiet();
    n_tests++;
    if ({collisionPulse, hitKind, lives} !== {1'b1, 1'b1, 4'd1} || obs !== expv) begin
      n_fail++; $display("FAIL border_only: got %h want %h", obs, expv);
    end
  endtask

  task automatic test_game_over();
    for (int f = 0; f < GF; f++) begin frame_body(4, 0, 0, 0, 0, 0); sof_quiet(); end
    frame_body(5, 1, 9, 9, 1, 0);
    sof_quiet();
    n_tests++;
    if ({collisionPulse, lives, gameOver, invulnerable} !== {1'b1, 4'd0, 1'b1, 1'b0} || obs !== expv) begin
      n_fail++; $display("FAIL game_over_enter: got %h want %h", obs, expv);
    end
    for (int f = 0; f < 2; f++) begin
      frame_body(5, 1, 11, 12, 1, 1);
      cyc(1, 0, 13, 14, 1, 1, 0);
      n_tests++;
      if ({collisionPulse, lives, gameOver} !== {1'b0, 4'd0, 1'b1} || obs !== expv) begin
        n_fail++; $display("FAIL game_over_sticky%0d: got %h want %h", f, obs, expv);
      end
    end
  endtask

  task automatic test_restart_collide();
    frame_body(5, 1, 40, 41, 1, 0);
    cyc(1, 1, 42, 43, 1, 1, 0);
    n_tests++;
    if ({collisionPulse, lives, gameOver, invulnerable} !== {1'b0, 4'd3, 1'b0, 1'b0} || obs !== expv) begin
      n_fail++; $display("FAIL restart_collide: got %h want %h", obs, expv);
    end
    frame_body(4, 0, 0, 0, 0, 0);
    sof_quiet();
    n_tests++;
    if (collisionPulse !== 1'b0 || lives !== 4'd3) begin
      n_fail++; $display("FAIL restart_dropped: got p=%0b l=%0d want 0/3", collisionPulse, lives);
    end
  endtask

  task automatic test_edge_timing();
    frame_body(5, 0, 0, 0, 0, 0);
    cyc(1, 0, 77, 88, 1, 1, 0);
    n_tests++;
    if ({collisionPulse, collisionX, collisionY, lives} !== {1'b1, 11'd77, 11'd88, 4'd2} || obs !== expv) begin
      n_fail++; $display("FAIL sof_overlap: got %h want %h", obs, expv);
    end
    cyc(0, 1, 0, 0, 0, 0, 0);
    frame_body(4, 1, 10, 20, 1, 0);
    // async reset mid-cycle, away from the clock edge
    #2 resetN = 0; model_reset();
    #3 resetN = 1;
    n_tests++;
    if (obs !== expv || collisionX !== 11'd0) begin
      n_fail++; $display("FAIL async_reset: got %h want %h", obs, expv);
    end
    frame_body(3, 0, 0, 0, 0, 0);
    sof_quiet();
    n_tests++;
    if (collisionPulse !== 1'b0 || lives !== 4'd3) begin
      n_fail++; $display("FAIL reset_drops_hit: got p=%0b l=%0d want 0/3", collisionPulse, lives);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(7) == 0), ($urandom_range(59) == 0),
          11'($urandom_range(2047)), 11'($urandom_range(2047)),
          ($urandom_range(1) == 0), ($urandom_range(3) == 0), ($urandom_range(6) == 0));
      n_tests++;
      if (obs !== expv) begin n_fail++; $display("FAIL random_cyc%0d: got %h want %h", i, obs, expv); end
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_grace();
    test_simultaneous();
    test_game_over();
    test_restart_collide();
    test_edge_timing();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
